// File: rtl/gate_scan_ctrl.sv
// rtl/gate_scan_ctrl.sv - exhaustive truth-table scan and compare for a small combinational gate
module gate_scan_ctrl #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected,
    input  logic                 gate_out,
    output logic [N_IN-1:0]      gate_in,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   truth,
    output logic                 pass,
    output logic [N_IN:0]        err_count
);

    localparam int              NVEC       = 2**N_IN;
    localparam logic [N_IN-1:0] LAST_VEC   = N_IN'(NVEC - 1);
    localparam logic [3:0]      SETTLE_CNT = 4'(SETTLE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t            state;
    logic [N_IN-1:0]   idx;
    logic [3:0]        cnt;
    logic [NVEC-1:0]   exp_q;

    logic              miss;
    logic [N_IN:0]     err_next;

    // Mismatch of the current sample against the table latched at start,
    // and the error count as it will stand after this sample.
    assign miss     = gate_out ^ exp_q[idx];
    assign err_next = err_count + {{N_IN{1'b0}}, miss};

    // Scan sequencer: all outputs are registered so gate_in never glitches.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            cnt       <= '0;
            exp_q     <= '0;
            gate_in   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            truth     <= '0;
            pass      <= 1'b0;
            err_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done    <= 1'b0;
                    gate_in <= '0;
                    if (start) begin
                        exp_q     <= expected;
                        idx       <= '0;
                        cnt       <= SETTLE_CNT;
                        truth     <= '0;
                        err_count <= '0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        truth[idx] <= gate_out;
                        err_count  <= err_next;
                        if (idx == LAST_VEC) begin
                            // Final verdict includes this last sample so pass
                            // is already valid in the done cycle.
                            pass    <= (err_next == '0);
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            gate_in <= '0;
                            state   <= ST_DONE;
                        end else begin
                            idx     <= idx + 1'b1;
                            gate_in <= idx + 1'b1;
                            cnt     <= SETTLE_CNT;
                        end
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    gate_in <= '0;
                    state   <= ST_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    gate_in <= '0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_scan_ctrl.sv
// tb/tb_gate_scan_ctrl.sv - directed self-checking bench for gate_scan_ctrl
module tb_gate_scan_ctrl;

    logic       clock;
    logic       reset_n;

    logic       start0;
    logic [3:0] expected0;
    logic       gate_out0;
    logic [1:0] gate_in0;
    logic       busy0;
    logic       done0;
    logic [3:0] truth0;
    logic       pass0;
    logic [2:0] err_count0;
    logic [1:0] gate_sel;

    logic       start1;
    logic [3:0] expected1;
    logic       gate_out1;
    logic [1:0] gate_in1;
    logic       busy1;
    logic       done1;
    logic [3:0] truth1;
    logic       pass1;
    logic [2:0] err_count1;

    int total;
    int passed;

    gate_scan_ctrl #(.N_IN(2), .SETTLE(1)) u_dut0 (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start0),
        .expected  (expected0),
        .gate_out  (gate_out0),
        .gate_in   (gate_in0),
        .busy      (busy0),
        .done      (done0),
        .truth     (truth0),
        .pass      (pass0),
        .err_count (err_count0)
    );

    gate_scan_ctrl #(.N_IN(2), .SETTLE(0)) u_dut1 (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start1),
        .expected  (expected1),
        .gate_out  (gate_out1),
        .gate_in   (gate_in1),
        .busy      (busy1),
        .done      (done1),
        .truth     (truth1),
        .pass      (pass1),
        .err_count (err_count1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Gate under test for instance 0: 0 = AND, 1 = NOR; a = gate_in[1], b = gate_in[0].
    always_comb begin
        gate_out0 = 1'b0;
        case (gate_sel)
            2'd0:    gate_out0 = gate_in0[1] & gate_in0[0];
            2'd1:    gate_out0 = ~(gate_in0[1] | gate_in0[0]);
            default: gate_out0 = 1'b0;
        endcase
    end

    // Gate under test for instance 1: OR.
    assign gate_out1 = gate_in1[1] | gate_in1[0];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic scan0(input logic [3:0] tbl, input logic [3:0] t_exp,
                         input logic [2:0] e_exp, input logic p_exp);
        expected0 = tbl;
        start0    = 1'b1;
        step();
        start0    = 1'b0;
        for (int e = 0; e < 8; e++) begin
            if (e > 0) step();
            check("scan_gate_in", 32'(gate_in0), 32'(e / 2));
            check("scan_busy", 32'(busy0), 32'd1);
            check("scan_done_low", 32'(done0), 32'd0);
        end
        step();
        check("end_done", 32'(done0), 32'd1);
        check("end_busy", 32'(busy0), 32'd0);
        check("end_gate_in", 32'(gate_in0), 32'd0);
        check("end_truth", 32'(truth0), 32'(t_exp));
        check("end_err_count", 32'(err_count0), 32'(e_exp));
        check("end_pass", 32'(p_exp ? 1 : 0), 32'(pass0));
        step();
        check("post_done", 32'(done0), 32'd0);
        check("post_truth_hold", 32'(truth0), 32'(t_exp));
        check("post_err_hold", 32'(err_count0), 32'(e_exp));
    endtask

    initial begin
        total     = 0;
        passed    = 0;
        gate_sel  = 2'd0;
        reset_n   = 1'b0;
        start0    = 1'b1;
        start1    = 1'b1;
        expected0 = 4'b1000;
        expected1 = 4'b1110;

        // Reset held with start asserted
        step();
        step();
        check("rst_gate_in", 32'(gate_in0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_truth", 32'(truth0), 32'd0);
        check("rst_pass", 32'(pass0), 32'd0);
        check("rst_err_count", 32'(err_count0), 32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);
        reset_n = 1'b1;
        start0  = 1'b0;
        start1  = 1'b0;
        step();
        check("idle_busy", 32'(busy0), 32'd0);

        // AND gate, expected AND table
        gate_sel = 2'd0;
        scan0(4'b1000, 4'b1000, 3'd0, 1'b1);

        // NOR gate against an XOR table
        gate_sel = 2'd1;
        scan0(4'b0110, 4'b0001, 3'd3, 1'b0);

        // AND scan disturbed by a second start and a changed expected table
        gate_sel  = 2'd0;
        expected0 = 4'b1000;
        start0    = 1'b1;
        step();
        start0    = 1'b0;
        step(); step(); step(); step();
        check("dist_gate_in_v2", 32'(gate_in0), 32'd2);
        start0    = 1'b1;
        expected0 = 4'b0000;
        step();
        start0    = 1'b0;
        step(); step();
        check("dist_done_low", 32'(done0), 32'd0);
        step();
        check("dist_done", 32'(done0), 32'd1);
        check("dist_truth", 32'(truth0), 32'h8);
        check("dist_pass", 32'(pass0), 32'd1);
        check("dist_err_count", 32'(err_count0), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("dist_no_rescan_busy", 32'(busy0), 32'd0);
            check("dist_no_rescan_done", 32'(done0), 32'd0);
        end

        // Reset mid-scan at vector 2, with a NOR gate so state is non-zero
        gate_sel  = 2'd1;
        expected0 = 4'b1000;
        start0    = 1'b1;
        step();
        start0    = 1'b0;
        step(); step(); step(); step();
        check("mid_gate_in_v2", 32'(gate_in0), 32'd2);
        check("mid_partial_truth", 32'(truth0), 32'h1);
        check("mid_partial_err", 32'(err_count0), 32'd1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("mid_rst_gate_in", 32'(gate_in0), 32'd0);
        check("mid_rst_busy", 32'(busy0), 32'd0);
        check("mid_rst_done", 32'(done0), 32'd0);
        check("mid_rst_truth", 32'(truth0), 32'd0);
        check("mid_rst_pass", 32'(pass0), 32'd0);
        check("mid_rst_err", 32'(err_count0), 32'd0);
        step();
        check("mid_rst_idle", 32'(busy0), 32'd0);
        gate_sel = 2'd0;
        scan0(4'b1000, 4'b1000, 3'd0, 1'b1);

        // SETTLE=0 instance with an OR gate
        expected1 = 4'b1110;
        start1    = 1'b1;
        step();
        start1    = 1'b0;
        for (int e = 0; e < 4; e++) begin
            if (e > 0) step();
            check("s0_gate_in", 32'(gate_in1), 32'(e));
            check("s0_busy", 32'(busy1), 32'd1);
            check("s0_done_low", 32'(done1), 32'd0);
        end
        step();
        check("s0_done", 32'(done1), 32'd1);
        check("s0_busy_end", 32'(busy1), 32'd0);
        check("s0_truth", 32'(truth1), 32'hE);
        check("s0_pass", 32'(pass1), 32'd1);
        check("s0_err_count", 32'(err_count1), 32'd0);
        step();
        check("s0_post_done", 32'(done1), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
